sub_pipe_unit: RTL and testbench

Parametrised, pipelined successor to the team's combinational 8-bit subtracter for the memory-to-memory transfer datapath. Accepts operand pairs over a valid/ready handshake and returns the difference two cycles later with borrow, overflow, saturation, zero and negative flags. Supports wrap, unsigned-saturate, signed-saturate and accumulate (running difference) modes. Sits between the memory read-data registers and the write-back path.

---
 rtl/sub_pkg.sv | 18 +
 rtl/sub_core.sv | 68 ++++++
 rtl/sub_pipe_unit.sv | 115 +++++++++++
 tb/tb_sub_pipe_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the pipelined subtracter: mode encodings and
// the bit positions of the flag bundle carried between core and pipeline.
`timescale 1ns/1ps
package sub_pkg;

  localparam logic [1:0] MODE_WRAP = 2'b00;
  localparam logic [1:0] MODE_USAT = 2'b01;
  localparam logic [1:0] MODE_SSAT = 2'b10;
  localparam logic [1:0] MODE_ACC  = 2'b11;

  localparam int FLAG_BORROW = 0;
  localparam int FLAG_OVF    = 1;
  localparam int FLAG_SAT    = 2;
  localparam int FLAG_ZERO   = 3;
  localparam int FLAG_NEG    = 4;
  localparam int FLAG_W      = 5;

endpackage

// File: rtl/sub_core.sv
// Combinational subtract core: minuend select, WIDTH+1 bit subtract,
// signed overflow detect, mode-dependent saturation and flag generation.
`timescale 1ns/1ps
module sub_core
  import sub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 2
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [WIDTH-1:0]  i_acc,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_acc_ld,
  output logic [WIDTH-1:0]  o_res,
  output logic [FLAG_W-1:0] o_flags
);

  logic [WIDTH-1:0] w_m;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_raw;
  logic             w_borrow;
  logic             w_ovf;
  logic             w_sat;
  logic [WIDTH-1:0] w_res;

  // Signed clamp value: most negative when the minuend was negative, else most positive.
  function automatic logic signed [WIDTH-1:0] ssat_bound(input logic neg_side);
    logic signed [WIDTH-1:0] v_max;
    v_max = {1'b0, {(WIDTH-1){1'b1}}};
    return neg_side ? ~v_max : v_max;
  endfunction

  always_comb begin
    w_m      = ((i_mode == MODE_ACC) && !i_acc_ld) ? i_acc : i_a;
    w_diff   = {1'b0, w_m} - {1'b0, i_b};
    w_borrow = w_diff[WIDTH];
    w_raw    = w_diff[WIDTH-1:0];
    w_ovf    = (w_m[WIDTH-1] != i_b[WIDTH-1]) && (w_raw[WIDTH-1] != w_m[WIDTH-1]);

    w_res = w_raw;
    w_sat = 1'b0;
    case (i_mode)
      MODE_USAT: begin
        if (w_borrow) begin
          w_res = '0;
          w_sat = 1'b1;
        end
      end
      MODE_SSAT: begin
        if (w_ovf) begin
          w_res = ssat_bound(w_m[WIDTH-1]);
          w_sat = 1'b1;
        end
      end
      default: ;
    endcase

    o_res                = w_res;
    o_flags              = '0;
    o_flags[FLAG_BORROW] = w_borrow;
    o_flags[FLAG_OVF]    = w_ovf;
    o_flags[FLAG_SAT]    = w_sat;
    o_flags[FLAG_ZERO]   = (w_res == '0);
    o_flags[FLAG_NEG]    = w_res[WIDTH-1];
  end

endmodule

// File: rtl/sub_pipe_unit.sv
// Two-stage valid/ready subtracter: stage 1 captures operands, stage 2 registers
// the core result and flags; also owns the running-difference accumulator.
`timescale 1ns/1ps
module sub_pipe_unit
  import sub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [MODE_W-1:0] in_mode,
  input  logic              in_acc_ld,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_res,
  output logic              out_borrow,
  output logic              out_ovf,
  output logic              out_sat,
  output logic              out_zero,
  output logic              out_neg
);

  logic              r_vld_p1;
  logic [WIDTH-1:0]  r_a_p1;
  logic [WIDTH-1:0]  r_b_p1;
  logic [MODE_W-1:0] r_mode_p1;
  logic              r_ld_p1;

  logic              r_vld_p2;
  logic [WIDTH-1:0]  r_res_p2;
  logic [FLAG_W-1:0] r_flags_p2;

  logic [WIDTH-1:0]  r_acc;

  logic              w_s2_adv;
  logic              w_s1_adv;
  logic              w_accept;
  logic [WIDTH-1:0]  w_res;
  logic [FLAG_W-1:0] w_flags;

  assign w_s2_adv = !r_vld_p2 || out_ready;
  assign w_s1_adv = r_vld_p1 && w_s2_adv;
  assign in_ready = !r_vld_p1 || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  // ---- stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_p1    <= in_a;
      r_b_p1    <= in_b;
      r_mode_p1 <= in_mode;
      r_ld_p1   <= in_acc_ld;
    end
  end

  sub_core #(
    .WIDTH  (WIDTH),
    .MODE_W (MODE_W)
  ) u_core (
    .i_a      (r_a_p1),
    .i_b      (r_b_p1),
    .i_acc    (r_acc),
    .i_mode   (r_mode_p1),
    .i_acc_ld (r_ld_p1),
    .o_res    (w_res),
    .o_flags  (w_flags)
  );

  // ---- stage 2: result/flag register and accumulator ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_res_p2   <= '0;
      r_flags_p2 <= '0;
      r_acc      <= '0;
    end else begin
      if (w_s2_adv) begin
        r_vld_p2 <= r_vld_p1;
      end
      if (w_s1_adv) begin
        r_res_p2   <= w_res;
        r_flags_p2 <= w_flags;
      end
      // Clear wins over a same-cycle ACC update; the retiring op already used the old acc.
      if (acc_clr) begin
        r_acc <= '0;
      end else if (w_s1_adv && (r_mode_p1 == MODE_ACC)) begin
        r_acc <= w_res;
      end
    end
  end

  assign out_valid  = r_vld_p2;
  assign out_res    = r_res_p2;
  assign out_borrow = r_flags_p2[FLAG_BORROW];
  assign out_ovf    = r_flags_p2[FLAG_OVF];
  assign out_sat    = r_flags_p2[FLAG_SAT];
  assign out_zero   = r_flags_p2[FLAG_ZERO];
  assign out_neg    = r_flags_p2[FLAG_NEG];

endmodule

// File: tb/tb_sub_pipe_unit.sv
// Directed bench for sub_pipe_unit: per-mode vectors, accumulator chain,
// backpressure ordering and asynchronous reset with pipeline full.
`timescale 1ns/1ps
module tb_sub_pipe_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_mode;
  logic       in_acc_ld;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic       out_borrow;
  logic       out_ovf;
  logic       out_sat;
  logic       out_zero;
  logic       out_neg;

  int n_chk = 0;
  int n_err = 0;

  sub_pipe_unit #(.WIDTH(8), .MODE_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_acc_ld  (in_acc_ld),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_borrow (out_borrow),
    .out_ovf    (out_ovf),
    .out_sat    (out_sat),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return 32'({out_borrow, out_ovf, out_sat, out_zero, out_neg});
  endfunction

  // Flag vector order: {borrow, ovf, sat, zero, neg}
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] mode, input logic ld,
                        input logic [7:0] er, input logic [4:0] ef);
    @(negedge clk);
    in_a = a; in_b = b; in_mode = mode; in_acc_ld = ld; in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(out_res), 32'(er));
    chk({tag, "_flg"}, flags(), 32'(ef));
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] mode, input logic ld);
    in_a = a; in_b = b; in_mode = mode; in_acc_ld = ld; in_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0;
    in_acc_ld = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(out_res), 32'd0);
    chk("rst_flg", flags(), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);

    run_op("wrap1",  8'h89, 8'h03, 2'b00, 1'b0, 8'h86, 5'b00001);
    run_op("wrap2",  8'hE3, 8'hFC, 2'b00, 1'b0, 8'hE7, 5'b10001);
    run_op("usat",   8'hE3, 8'hFC, 2'b01, 1'b0, 8'h00, 5'b10110);
    run_op("usat_ok",8'h40, 8'h10, 2'b01, 1'b0, 8'h30, 5'b00000);
    run_op("ssat1",  8'h1B, 8'h53, 2'b10, 1'b0, 8'hC8, 5'b10001);
    run_op("ssat2",  8'h80, 8'h01, 2'b10, 1'b0, 8'h80, 5'b01101);
    run_op("ssat3",  8'h7F, 8'hFF, 2'b10, 1'b0, 8'h7F, 5'b11100);
    run_op("wrap_ov",8'h7F, 8'hFF, 2'b00, 1'b0, 8'h80, 5'b11001);

    run_op("acc1",   8'h64, 8'h0A, 2'b11, 1'b1, 8'h5A, 5'b00000);
    run_op("acc2",   8'h00, 8'h14, 2'b11, 1'b0, 8'h46, 5'b00000);
    run_op("acc3",   8'h00, 8'h50, 2'b11, 1'b0, 8'hF6, 5'b10001);
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    run_op("nonacc", 8'h10, 8'h01, 2'b00, 1'b0, 8'h0F, 5'b00000);
    run_op("acc_clr",8'h33, 8'h01, 2'b11, 1'b0, 8'hFF, 5'b10001);

    // Backpressure: stall output, fill both stages, then release.
    @(negedge clk);
    chk("bp_idle", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(8'h05, 8'h01, 2'b00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_rdy2", 32'(in_ready), 32'd1);
    drive(8'h09, 8'h02, 2'b00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8'h20, 8'h10, 2'b00, 1'b0);
    chk("bp_rdy3", 32'(in_ready), 32'd0);
    chk("bp_vld",  32'(out_valid), 32'd1);
    chk("bp_res0", 32'(out_res), 32'h04);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_res", 32'(out_res), 32'h04);
    out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_res1", 32'(out_res), 32'h07);
    chk("bp_vld1", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_res2", 32'(out_res), 32'h10);
    chk("bp_vld2", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Reset with both stages full and a nonzero accumulator.
    out_ready = 1'b0;
    drive(8'h30, 8'h10, 2'b11, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(8'h01, 8'h01, 2'b00, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mr_full", 32'(out_valid), 32'd1);
    chk("mr_res",  32'(out_res), 32'h20);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_vld0", 32'(out_valid), 32'd0);
    chk("mr_res0", 32'(out_res), 32'd0);
    chk("mr_flg0", flags(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mr_rdy", 32'(in_ready), 32'd1);
    run_op("mr_op",  8'h42, 8'h02, 2'b00, 1'b0, 8'h40, 5'b00000);
    run_op("mr_acc", 8'h55, 8'h01, 2'b11, 1'b0, 8'hFF, 5'b10001);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
